// File: rtl/sdram_responder_pkg.sv
// sdram_responder_pkg
// Shared definitions for the SDRAM responder model: command encodings
// ({ras,cas,we}), init-sequence states and error-cause codes.
package sdram_responder_pkg;

    // Command encoding as seen on {ras, cas, we} when cke=1 and cs=0.
    typedef enum logic [2:0] {
        CMD_MRS       = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACT       = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_BST       = 3'b110,
        CMD_NOP       = 3'b111
    } sdram_cmd_e;

    // Power-up sequence: PALL, two CBR refreshes, MRS, then operational.
    typedef enum logic [2:0] {
        INIT_WAIT_PALL = 3'd0,
        INIT_WAIT_CBR1 = 3'd1,
        INIT_WAIT_CBR2 = 3'd2,
        INIT_WAIT_MRS  = 3'd3,
        INIT_READY     = 3'd4
    } init_state_e;

    // Error causes; a lower code wins when several fire on one edge.
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_INIT_ORDER   = 3'd1;
    localparam logic [2:0] ERR_CLOSED_BANK  = 3'd2;
    localparam logic [2:0] ERR_ACT_OPEN     = 3'd3;
    localparam logic [2:0] ERR_BAD_CL       = 3'd4;
    localparam logic [2:0] ERR_WRITE_DIR    = 3'd5;
    localparam logic [2:0] ERR_REFRESH_OPEN = 3'd6;

    // Only CAS latencies 2 and 3 are modelled.
    function automatic logic cl_supported(input logic [2:0] cl);
        return (cl == 3'd2) || (cl == 3'd3);
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// sdram_responder_if
// SDRAM pin bundle between a controller (master) and the responder (slave).
//   master drives: sdram_address, sdram_cke, sdram_cs, sdram_ras, sdram_cas,
//                  sdram_we, sdram_ba, sdram_dq_in, sdram_dq_io
//   slave drives:  sdram_dq_out, sdram_dq_oe, ready, cas_latency, error,
//                  error_code
interface sdram_responder_if #(
    parameter int unsigned sdram_row_width  = 13,
    parameter int unsigned sdram_bank_width = 2,
    parameter int unsigned sdram_data_width = 16
);
    logic [sdram_row_width-1:0]  sdram_address;
    logic                        sdram_cke;
    logic                        sdram_cs;
    logic                        sdram_ras;
    logic                        sdram_cas;
    logic                        sdram_we;
    logic [sdram_bank_width-1:0] sdram_ba;
    logic [sdram_data_width-1:0] sdram_dq_in;
    logic                        sdram_dq_io;
    logic [sdram_data_width-1:0] sdram_dq_out;
    logic                        sdram_dq_oe;
    logic                        ready;
    logic [2:0]                  cas_latency;
    logic                        error;
    logic [2:0]                  error_code;

    modport master (
        output sdram_address, sdram_cke, sdram_cs, sdram_ras, sdram_cas,
               sdram_we, sdram_ba, sdram_dq_in, sdram_dq_io,
        input  sdram_dq_out, sdram_dq_oe, ready, cas_latency, error, error_code
    );

    modport slave (
        input  sdram_address, sdram_cke, sdram_cs, sdram_ras, sdram_cas,
               sdram_we, sdram_ba, sdram_dq_in, sdram_dq_io,
        output sdram_dq_out, sdram_dq_oe, ready, cas_latency, error, error_code
    );
endinterface

// File: rtl/sdram_responder_mem.sv
// sdram_responder_mem
// Single-port backing store: synchronous write, combinational read.
//   clk      in   clock
//   we       in   write enable
//   addr     in   shared read/write address
//   wdata    in   write data
//   rdata_c  out  combinational read data at addr
module sdram_responder_mem #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned data_width = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata_c
);
    localparam int unsigned depth = 2 ** addr_width;

    logic [data_width-1:0] mem [depth];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder
// Behavioural SDRAM device: checks the power-up sequence, tracks open
// banks/rows, stores burst-length-1 writes and returns reads after the
// programmed CAS latency. Protocol violations latch a sticky error code.
//   sdram_clock  in  clock
//   sdram_reset  in  asynchronous active-high reset
//   bus          slave modport of sdram_responder_if (command pins in,
//                read data / status out)
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int unsigned sdram_col_width  = 10,
    parameter int unsigned sdram_row_width  = 13,
    parameter int unsigned sdram_bank_width = 2,
    parameter int unsigned sdram_data_width = 16,
    parameter int unsigned mem_row_bits     = 4,
    parameter int unsigned mem_col_bits     = 4
) (
    input logic              sdram_clock,
    input logic              sdram_reset,
    sdram_responder_if.slave bus
);
    localparam int unsigned nbanks         = 2 ** sdram_bank_width;
    localparam int unsigned mem_addr_width = sdram_bank_width + mem_row_bits + mem_col_bits;
    // Stored column index never reaches beyond the column field of the bus.
    localparam int unsigned col_sel_bits   = (mem_col_bits <= sdram_col_width) ? mem_col_bits
                                                                               : sdram_col_width;

    localparam logic [2:0] ST_WAIT_PALL = 3'(INIT_WAIT_PALL);
    localparam logic [2:0] ST_WAIT_CBR1 = 3'(INIT_WAIT_CBR1);
    localparam logic [2:0] ST_WAIT_CBR2 = 3'(INIT_WAIT_CBR2);
    localparam logic [2:0] ST_WAIT_MRS  = 3'(INIT_WAIT_MRS);
    localparam logic [2:0] ST_READY     = 3'(INIT_READY);

    logic [2:0]                  state, state_nxt;
    logic [nbanks-1:0]           bank_open, bank_open_nxt;
    logic [mem_row_bits-1:0]     bank_row [nbanks];
    logic [mem_row_bits-1:0]     bank_row_nxt [nbanks];
    logic [2:0]                  cas_latency_q, cl_nxt;
    logic                        error_q;
    logic [2:0]                  error_code_q;
    logic                        ready_q;
    logic                        dq_oe_q;
    logic [sdram_data_width-1:0] dq_out_q;

    logic [1:0]                  pipe_vld;
    logic [sdram_data_width-1:0] pipe_data [2];

    sdram_cmd_e                  cmd_c;
    logic [2:0]                  err_c;
    logic [2:0]                  mode_cl_c;
    logic                        mem_we_c;
    logic                        rd_fire_c;
    logic                        rd_hit_c;
    logic [mem_col_bits-1:0]     col_c;
    logic [mem_addr_width-1:0]   mem_addr_c;
    logic [sdram_data_width-1:0] mem_rdata_c;
    logic                        sel_vld_c;
    logic [sdram_data_width-1:0] sel_data_c;
    logic                        unused_addr_c;

    // Command decode; deselect, clock-disable and burst-terminate all act as NOP.
    always_comb begin
        cmd_c = CMD_NOP;
        if (bus.sdram_cke && !bus.sdram_cs) begin
            cmd_c = sdram_cmd_e'({bus.sdram_ras, bus.sdram_cas, bus.sdram_we});
        end
        if (cmd_c == CMD_BST) begin
            cmd_c = CMD_NOP;
        end
    end

    assign mode_cl_c     = bus.sdram_address[6:4];
    assign col_c         = mem_col_bits'(bus.sdram_address[col_sel_bits-1:0]);
    assign mem_addr_c    = {bus.sdram_ba, bank_row[bus.sdram_ba], col_c};
    assign rd_hit_c      = bank_open[bus.sdram_ba];
    assign unused_addr_c = ^bus.sdram_address;

    // Next-state: init sequencing, bank bookkeeping and error detection.
    always_comb begin
        state_nxt     = state;
        bank_open_nxt = bank_open;
        bank_row_nxt  = bank_row;
        cl_nxt        = cas_latency_q;
        err_c         = ERR_NONE;
        mem_we_c      = 1'b0;
        rd_fire_c     = 1'b0;

        case (state)
            ST_WAIT_PALL: begin
                if (cmd_c == CMD_PRECHARGE && bus.sdram_address[10]) begin
                    state_nxt = ST_WAIT_CBR1;
                end else if (cmd_c != CMD_NOP) begin
                    err_c = ERR_INIT_ORDER;
                end
            end
            ST_WAIT_CBR1: begin
                if (cmd_c == CMD_REFRESH) begin
                    state_nxt = ST_WAIT_CBR2;
                end else if (cmd_c != CMD_NOP) begin
                    err_c = ERR_INIT_ORDER;
                end
            end
            ST_WAIT_CBR2: begin
                if (cmd_c == CMD_REFRESH) begin
                    state_nxt = ST_WAIT_MRS;
                end else if (cmd_c != CMD_NOP) begin
                    err_c = ERR_INIT_ORDER;
                end
            end
            ST_WAIT_MRS: begin
                if (cmd_c == CMD_MRS) begin
                    state_nxt = ST_READY;
                    if (cl_supported(mode_cl_c)) begin
                        cl_nxt = mode_cl_c;
                    end else begin
                        err_c = ERR_BAD_CL;
                    end
                end else if (cmd_c != CMD_NOP) begin
                    err_c = ERR_INIT_ORDER;
                end
            end
            ST_READY: begin
                case (cmd_c)
                    CMD_ACT: begin
                        if (bank_open[bus.sdram_ba]) begin
                            err_c = ERR_ACT_OPEN;
                        end else begin
                            bank_open_nxt[bus.sdram_ba] = 1'b1;
                            bank_row_nxt[bus.sdram_ba]  = bus.sdram_address[mem_row_bits-1:0];
                        end
                    end
                    CMD_READ: begin
                        rd_fire_c = 1'b1;
                        if (!rd_hit_c) begin
                            err_c = ERR_CLOSED_BANK;
                        end
                    end
                    CMD_WRITE: begin
                        // Wrong bus direction is flagged but the write still lands.
                        if (!rd_hit_c) begin
                            err_c = ERR_CLOSED_BANK;
                        end else begin
                            mem_we_c = 1'b1;
                            if (bus.sdram_dq_io) begin
                                err_c = ERR_WRITE_DIR;
                            end
                        end
                    end
                    CMD_PRECHARGE: begin
                        if (bus.sdram_address[10]) begin
                            bank_open_nxt = '0;
                        end else begin
                            bank_open_nxt[bus.sdram_ba] = 1'b0;
                        end
                    end
                    CMD_REFRESH: begin
                        if (|bank_open) begin
                            err_c = ERR_REFRESH_OPEN;
                        end
                    end
                    CMD_MRS: begin
                        if (cl_supported(mode_cl_c)) begin
                            cl_nxt = mode_cl_c;
                        end else begin
                            err_c = ERR_BAD_CL;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_nxt = ST_WAIT_PALL;
        endcase
    end

    // Read return tap: stage 0 for CL2, stage 1 for CL3.
    always_comb begin
        sel_vld_c  = pipe_vld[0];
        sel_data_c = pipe_data[0];
        if (cas_latency_q == 3'd3) begin
            sel_vld_c  = pipe_vld[1];
            sel_data_c = pipe_data[1];
        end
    end

    // State, bank table, status and read pipeline registers.
    always_ff @(posedge sdram_clock or posedge sdram_reset) begin
        if (sdram_reset) begin
            state         <= ST_WAIT_PALL;
            bank_open     <= '0;
            bank_row      <= '{default: '0};
            cas_latency_q <= 3'd0;
            error_q       <= 1'b0;
            error_code_q  <= ERR_NONE;
            ready_q       <= 1'b0;
            pipe_vld      <= '0;
            pipe_data     <= '{default: '0};
            dq_oe_q       <= 1'b0;
            dq_out_q      <= '0;
        end else begin
            state         <= state_nxt;
            bank_open     <= bank_open_nxt;
            bank_row      <= bank_row_nxt;
            cas_latency_q <= cl_nxt;
            ready_q       <= (state_nxt == ST_READY);
            if (!error_q && err_c != ERR_NONE) begin
                error_q      <= 1'b1;
                error_code_q <= err_c;
            end
            // A read to a closed bank still returns a (zero) data beat.
            pipe_vld[0]  <= rd_fire_c;
            pipe_data[0] <= (rd_fire_c && rd_hit_c) ? mem_rdata_c : '0;
            pipe_vld[1]  <= pipe_vld[0];
            pipe_data[1] <= pipe_data[0];
            dq_oe_q      <= sel_vld_c;
            dq_out_q     <= sel_vld_c ? sel_data_c : '0;
        end
    end

    sdram_responder_mem #(
        .addr_width (mem_addr_width),
        .data_width (sdram_data_width)
    ) u_mem (
        .clk     (sdram_clock),
        .we      (mem_we_c),
        .addr    (mem_addr_c),
        .wdata   (bus.sdram_dq_in),
        .rdata_c (mem_rdata_c)
    );

    assign bus.sdram_dq_out = dq_out_q;
    assign bus.sdram_dq_oe  = dq_oe_q;
    assign bus.ready        = ready_q;
    assign bus.cas_latency  = cas_latency_q;
    assign bus.error        = error_q;
    assign bus.error_code   = error_code_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder
// Scoreboard bench: each command updates a behavioural device model; reads
// push their expected word and due cycle into a queue which a negedge
// monitor pops whenever dq_oe is seen. Status outputs are compared every cycle.
module tb_sdram_responder;
    import sdram_responder_pkg::*;

    localparam int unsigned ROW_W  = 13;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned MROW   = 4;
    localparam int unsigned MCOL   = 4;

    logic clk;
    logic rst;

    sdram_responder_if #(
        .sdram_row_width  (ROW_W),
        .sdram_bank_width (BANK_W),
        .sdram_data_width (DATA_W)
    ) bus ();

    sdram_responder #(
        .sdram_col_width  (COL_W),
        .sdram_row_width  (ROW_W),
        .sdram_bank_width (BANK_W),
        .sdram_data_width (DATA_W),
        .mem_row_bits     (MROW),
        .mem_col_bits     (MCOL)
    ) dut (
        .sdram_clock (clk),
        .sdram_reset (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int due;
    } exp_t;

    // Reference model state.
    int   m_phase;     // init steps completed; 4 = operational
    bit   m_open [4];
    int   m_row  [4];
    int   m_cl;
    bit   m_err;
    int   m_code;
    int   m_mem [int];
    exp_t rq [$];

    int vectors    = 0;
    int miscompares = 0;
    int edge_cnt   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, edge_cnt, got, want);
        end
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_cl    = 0;
        m_err   = 1'b0;
        m_code  = 0;
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 1'b0;
        end
        rq.delete();
    endfunction

    function automatic int mkey(input int ba, input int addr);
        return (ba << 8) | ((m_row[ba] & 15) << 4) | (addr & 15);
    endfunction

    function automatic int mode_cl(input int addr, inout int err);
        int v;
        v = (addr >> 4) & 7;
        if (v == 2 || v == 3) return v;
        err = 4;
        return m_cl;
    endfunction

    // Device behaviour at the sampling edge; e = edge count just before it.
    function automatic void model_step(input bit cke, input bit cs, input logic [2:0] c,
                                       input int ba, input int addr, input int dq,
                                       input bit io, input int e);
        int  err;
        int  key;
        bit  a10;
        err = 0;
        a10 = ((addr >> 10) & 1) != 0;
        if (!cke || cs || c == 3'b110) c = 3'b111;
        if (m_phase < 4) begin
            if (c != 3'b111) begin
                if (m_phase == 0 && c == 3'(CMD_PRECHARGE) && a10) m_phase = 1;
                else if ((m_phase == 1 || m_phase == 2) && c == 3'(CMD_REFRESH)) m_phase++;
                else if (m_phase == 3 && c == 3'(CMD_MRS)) begin
                    m_cl    = mode_cl(addr, err);
                    m_phase = 4;
                end else err = 1;
            end
        end else begin
            key = mkey(ba, addr);
            case (c)
                3'(CMD_ACT): begin
                    if (m_open[ba]) err = 3;
                    else begin
                        m_open[ba] = 1'b1;
                        m_row[ba]  = addr & 15;
                    end
                end
                3'(CMD_READ): begin
                    if (!m_open[ba]) begin
                        err = 2;
                        rq.push_back('{data: 0, due: e + m_cl});
                    end else begin
                        rq.push_back('{data: m_mem[key], due: e + m_cl});
                    end
                end
                3'(CMD_WRITE): begin
                    if (!m_open[ba]) err = 2;
                    else begin
                        m_mem[key] = dq & 16'hFFFF;
                        if (io) err = 5;
                    end
                end
                3'(CMD_PRECHARGE): begin
                    if (a10) for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
                    else m_open[ba] = 1'b0;
                end
                3'(CMD_REFRESH): begin
                    if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) err = 6;
                end
                3'(CMD_MRS): m_cl = mode_cl(addr, err);
                default: ;
            endcase
        end
        if (err != 0 && !m_err) begin
            m_err  = 1'b1;
            m_code = err;
        end
    endfunction

    task automatic drive_idle();
        bus.sdram_cke     = 1'b1;
        bus.sdram_cs      = 1'b1;
        bus.sdram_ras     = 1'b1;
        bus.sdram_cas     = 1'b1;
        bus.sdram_we      = 1'b1;
        bus.sdram_ba      = '0;
        bus.sdram_address = '0;
        bus.sdram_dq_in   = '0;
        bus.sdram_dq_io   = 1'b1;
    endtask

    task automatic issue(input bit cke, input bit cs, input logic [2:0] c, input int ba,
                         input int addr, input int dq, input bit io);
        int e;
        @(negedge clk);
        bus.sdram_cke     = cke;
        bus.sdram_cs      = cs;
        {bus.sdram_ras, bus.sdram_cas, bus.sdram_we} = c;
        bus.sdram_ba      = BANK_W'(ba);
        bus.sdram_address = ROW_W'(addr);
        bus.sdram_dq_in   = DATA_W'(dq);
        bus.sdram_dq_io   = io;
        e = edge_cnt;
        @(posedge clk);
        model_step(cke, cs, c, ba, addr, dq, io, e);
    endtask

    task automatic cmd(input logic [2:0] c, input int ba, input int addr, input int dq, input bit io);
        issue(1'b1, 1'b0, c, ba, addr, dq, io);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cmd(3'(CMD_NOP), 0, 0, 0, 1'b1);
    endtask

    task automatic init_seq(input int mrs_addr);
        cmd(3'(CMD_PRECHARGE), 0, 1 << 10, 0, 1'b1);
        cmd(3'(CMD_REFRESH), 0, 0, 0, 1'b1);
        cmd(3'(CMD_REFRESH), 0, 0, 0, 1'b1);
        cmd(3'(CMD_MRS), 0, mrs_addr, 0, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1;
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Read-data scoreboard and per-cycle status comparison.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (bus.sdram_dq_oe) begin
            vectors++;
            if (rq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_dq_oe at cycle %0d: got dq_out=%0h, required no read beat",
                         edge_cnt, bus.sdram_dq_out);
            end else begin
                x = rq.pop_front();
                if (x.due != edge_cnt || int'(bus.sdram_dq_out) != x.data) begin
                    miscompares++;
                    $display("FAIL read_data at cycle %0d: got %0h, required %0h due at cycle %0d",
                             edge_cnt, bus.sdram_dq_out, x.data, x.due);
                end
            end
        end else begin
            chk("idle_dq_out_zero", int'(bus.sdram_dq_out), 0);
            if (rq.size() != 0 && rq[0].due <= edge_cnt) begin
                x = rq.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_read at cycle %0d: got dq_oe=0, required data %0h due at cycle %0d",
                         edge_cnt, x.data, x.due);
            end
        end
        chk("ready", int'(bus.ready), int'(m_phase == 4));
        chk("cas_latency", int'(bus.cas_latency), m_cl);
        chk("error", int'(bus.error), int'(m_err));
        chk("error_code", int'(bus.error_code), m_code);
    end

    initial begin : stimulus
        int sel;
        int rba;
        int raddr;
        int rdq;
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Init to CL3, single write/read, then a CL2 back-to-back burst.
        init_seq('h030);
        nops(2);
        cmd(3'(CMD_ACT), 1, 5, 0, 1'b0);
        cmd(3'(CMD_WRITE), 1, 3, 'hA5A5, 1'b0);
        cmd(3'(CMD_READ), 1, 3, 0, 1'b1);
        nops(5);
        for (int i = 0; i < 4; i++) cmd(3'(CMD_WRITE), 1, i, 'h1111 * (i + 1), 1'b0);
        nops(4);
        cmd(3'(CMD_MRS), 0, 'h020, 0, 1'b1);
        for (int i = 0; i < 4; i++) cmd(3'(CMD_READ), 1, i, 0, 1'b1);
        cmd(3'(CMD_WRITE), 1, 7, 'h5A5A, 1'b0);
        cmd(3'(CMD_READ), 1, 7, 0, 1'b1);
        nops(4);

        // Closed-bank read, then ACT to an already open bank.
        cmd(3'(CMD_READ), 2, 0, 0, 1'b1);
        nops(3);
        cmd(3'(CMD_ACT), 1, 7, 0, 1'b0);
        nops(3);

        // Out-of-order command during init.
        do_reset(2);
        cmd(3'(CMD_ACT), 0, 1, 0, 1'b0);
        cmd(3'(CMD_REFRESH), 0, 0, 0, 1'b1);
        nops(2);
        init_seq('h030);
        nops(3);

        // Randomized traffic from a fresh start.
        do_reset(2);
        init_seq(($urandom_range(0, 1) == 0) ? 'h020 : 'h030);
        for (int n = 0; n < 800; n++) begin
            sel   = $urandom_range(0, 99);
            rba   = $urandom_range(0, 3);
            raddr = $urandom_range(0, 8191);
            rdq   = $urandom_range(0, 65535);
            if (sel < 15) begin
                cmd(3'(CMD_ACT), rba, raddr, rdq, 1'b0);
            end else if (sel < 40) begin
                if (m_open[rba] && !m_mem.exists(mkey(rba, raddr)))
                    cmd(3'(CMD_WRITE), rba, raddr, rdq, 1'b0);
                else
                    cmd(3'(CMD_READ), rba, raddr, rdq, 1'($urandom_range(0, 1)));
            end else if (sel < 62) begin
                cmd(3'(CMD_WRITE), rba, raddr, rdq, ($urandom_range(0, 19) == 0));
            end else if (sel < 72) begin
                cmd(3'(CMD_PRECHARGE), rba, raddr, rdq, 1'b1);
            end else if (sel < 75) begin
                cmd(3'(CMD_REFRESH), rba, raddr, rdq, 1'b1);
            end else if (sel < 76) begin
                cmd(3'(CMD_MRS), 0, $urandom_range(4, 7) << 4, 0, 1'b1);
            end else if (sel < 82) begin
                issue(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rba, raddr, rdq, 1'b0);
            end else if (sel < 88) begin
                issue(1'b1, 1'b1, 3'($urandom_range(0, 7)), rba, raddr, rdq, 1'b0);
            end else begin
                nops(1);
            end
        end
        nops(5);

        // Reset between a read and its data; stored data survives re-init.
        do_reset(2);
        init_seq('h030);
        cmd(3'(CMD_ACT), 3, 9, 0, 1'b0);
        cmd(3'(CMD_WRITE), 3, 6, 'hBEEF, 1'b0);
        cmd(3'(CMD_READ), 3, 6, 0, 1'b1);
        do_reset(3);
        nops(2);
        init_seq('h030);
        cmd(3'(CMD_ACT), 3, 9, 0, 1'b0);
        cmd(3'(CMD_READ), 3, 6, 0, 1'b1);
        nops(6);

        chk("read_queue_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 The block SHALL have parameter sdram_col_width, default 10, column address bus width.
REQ-002 The block SHALL have parameter sdram_row_width, default 13, address bus width; must be at least 11.
REQ-003 The block SHALL have parameter sdram_bank_width, default 2, bank bus width.
REQ-004 The block SHALL have parameter sdram_data_width, default 16, DQ width.
REQ-005 The block SHALL have parameters mem_row_bits and mem_col_bits, defaults 4 and 4, giving the stored rows and columns per bank; backing store = 2^(bank+row+col) words.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset, on ports sdram_clock and sdram_reset.
REQ-007 Ports SHALL be:
- sdram_clock  in  1  clock
- sdram_reset  in  1  async active-high reset
- sdram_address  in  sdram_row_width  row, column or mode bits
- sdram_cke  in  1  clock enable
- sdram_cs, sdram_ras, sdram_cas, sdram_we  in  1 each  active-low command
- sdram_ba  in  sdram_bank_width  bank
- sdram_dq_in  in  sdram_data_width  write data from the controller
- sdram_dq_io  in  1  controller direction; 0 = controller drives
- sdram_dq_out  out  sdram_data_width  read data
- sdram_dq_oe  out  1  responder drives read data
- ready  out  1  init sequence complete
- cas_latency  out  3  latched CL
- error  out  1  sticky protocol error
- error_code  out  3  first error cause

Function
REQ-008 Commands SHALL be decoded on every rising edge where cke=1 and cs=0, using {ras,cas,we}:
- 111 NOP
- 011 ACT
- 101 READ
- 100 WRITE
- 010 PRECHARGE (A10=1: all banks, else bank ba)
- 001 REFRESH
- 000 MRS
cs=1 or cke=0 SHALL be treated as NOP.
REQ-009 The init FSM SHALL have states WAIT_PALL, WAIT_CBR1, WAIT_CBR2, WAIT_MRS and READY, advancing on PALL, REFRESH, REFRESH and MRS respectively.
- NOP holds the state.
- Any other command before READY sets error code 1 and holds the state.
REQ-010 MRS SHALL latch cas_latency = address[6:4]. A value other than 2 or 3 sets error code 4, and the previous value is kept.
REQ-011 Per bank, the block SHALL track the open flag and the row (low mem_row_bits of address at ACT).
- ACT to an open bank: error code 3.
- PRECHARGE closes the bank(s); precharging a closed bank is legal.
REQ-012 WRITE (burst length 1) SHALL store sdram_dq_in at the edge the command is sampled.
- Store address = {ba, open row, address[mem_col_bits-1:0]}.
- WRITE with sdram_dq_io=1: error code 5, and the write still occurs.
REQ-013 For a READ sampled at edge E, the block SHALL read the stored word at E. The word appears on sdram_dq_out with sdram_dq_oe=1 after edge E+CL-1 and is held for exactly one cycle, so it is valid at edge E+CL.
REQ-014 Back-to-back READs SHALL produce back-to-back data with no bubble. This uses a CL-1 deep valid/data pipeline.
REQ-015 A READ at edge E+1 to an address written at edge E SHALL return the new data.
REQ-016 READ or WRITE to a closed bank SHALL set error code 2; the write is dropped, and the read returns 0 with dq_oe=1.
REQ-017 REFRESH while any bank is open SHALL set error code 6.
REQ-018 error SHALL be sticky, and error_code SHALL keep the first error. Priority on a single edge is by lowest code.
REQ-019 When sdram_dq_oe=0, sdram_dq_out SHALL be 0.

Reset
REQ-020 On reset the outputs SHALL be: sdram_dq_out=0, sdram_dq_oe=0, ready=0, cas_latency=0, error=0, error_code=0.
REQ-021 Reset SHALL return the FSM to WAIT_PALL, close all banks and flush the read pipeline.
REQ-022 Reset mid-burst SHALL discard in-flight read data; memory contents are not cleared and not guaranteed.

Structure
REQ-023 Package sdram_responder_pkg SHALL hold the command enum, the init-state enum and the error-code constants (1..6).
REQ-024 The backing store SHALL be sub-module sdram_responder_mem: single port, synchronous write, combinational read.

Verification
REQ-025 Bench scenarios SHALL be:
- Init: PALL, REFRESH x2, MRS with address=0x030 -> ready=1 after the MRS edge, cas_latency=3, error=0.
- CL3 single access: ACT bank1 row5, WRITE col3 data 0xA5A5, READ col3 at edge E -> dq_out=0xA5A5 and dq_oe=1 only during the cycle before edge E+3.
- CL2 burst: MRS with address=0x020, four consecutive READs of cols 0-3 (written 0x1111..0x4444) -> four consecutive data cycles in order, no gaps.
- Errors: READ to closed bank 2 -> error=1, error_code=2, dq_out=0. A subsequent ACT to an open bank keeps error_code=2.
- Init error: ACT before PALL -> error_code=1 and the FSM stays in WAIT_PALL.
- Reset mid-read: assert reset between a READ and its data -> dq_oe never asserts, ready=0, and the earlier-written data is readable after re-init.
